// File: rtl/bga_lab_pkg.sv
// Shared definitions for the BGA lab pin-pair scan blocks.
package bga_lab_pkg;
  localparam int         N_PAIR_DEFAULT = 86;
  localparam logic [7:0] PASS_CODE      = 8'hFF;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start low, 8 data bits LSB first, stop high, BAUD_DIV clk per bit.
// busy drops in the last stop-bit cycle so a waiting byte follows with no idle gap.
import bga_lab_pkg::*;

module uart_tx_8n1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       txd
);
  localparam int             CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(BAUD_DIV - 1);

  tx_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [2:0]    bitc, bit_nxt;
  logic          txd_nxt;
  logic          bit_end;

  assign bit_end = (cnt == LAST);
  assign busy    = !((state == IDLE) || (state == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      bitc  <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
      bitc  <= bit_nxt;
      txd   <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    bit_nxt   = bitc;
    txd_nxt   = txd;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = START;
          sh_nxt    = data;
          cnt_nxt   = '0;
          txd_nxt   = 1'b0;
        end
      end
      START: begin
        cnt_nxt = cnt + 1'b1;
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
          bit_nxt   = '0;
          txd_nxt   = sh[0];
        end
      end
      DATA: begin
        cnt_nxt = cnt + 1'b1;
        if (bit_end) begin
          cnt_nxt = '0;
          if (bitc == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            sh_nxt  = {1'b0, sh[7:1]};
            txd_nxt = sh[1];
            bit_nxt = bitc + 3'd1;
          end
        end
      end
      STOP: begin
        cnt_nxt = cnt + 1'b1;
        if (bit_end) begin
          cnt_nxt = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (start) begin
            state_nxt = START;
            sh_nxt    = data;
            txd_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/pair_fault_logger.sv
// Logs each pin pair's first scan failure as a byte {0,index} over UART; optional
// PAIR_FAULT_PASS_SUMMARY_EN adds one 0xFF byte after a clean round. Full FIFO drops and flags overflow.
import bga_lab_pkg::*;

module pair_fault_logger #(
  parameter int N_PAIR     = N_PAIR_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_valid,
  input  logic [6:0] step_index,
  input  logic       step_fail,
  output logic       txd,
  output logic       fault_seen,
  output logic [7:0] fault_count,
  output logic       overflow
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  N_PAIR_W = 8'(N_PAIR);

  logic [N_PAIR-1:0] logged;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic       step_ok, new_fail, sum_push, push, push_ok, pop, full, empty, tx_busy;
  logic [7:0] push_dat;

  assign step_ok  = step_valid && ({1'b0, step_index} < N_PAIR_W);
  assign new_fail = step_ok && step_fail && !logged[step_index];

`ifdef PAIR_FAULT_PASS_SUMMARY_EN
  logic round_clean, summary_done, last_idx;

  assign last_idx = ({1'b0, step_index} == N_PAIR_W - 8'd1);
  assign sum_push = step_ok && last_idx && !step_fail && round_clean && !summary_done;

  // A round runs from just after one last-index step up to and including the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_clean  <= 1'b1;
      summary_done <= 1'b0;
    end else if (step_ok) begin
      if (last_idx)
        round_clean <= 1'b1;
      else if (step_fail)
        round_clean <= 1'b0;
      if (sum_push)
        summary_done <= 1'b1;
    end
  end
`else
  assign sum_push = 1'b0;
`endif

  assign push     = new_fail || sum_push;
  assign push_dat = new_fail ? {1'b0, step_index} : PASS_CODE;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop      = !tx_busy && !empty;
  assign push_ok  = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      logged      <= '0;
      fault_seen  <= 1'b0;
      fault_count <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      // The map and counters update even when the record itself is dropped.
      if (new_fail) begin
        logged[step_index] <= 1'b1;
        fault_seen         <= 1'b1;
        if (fault_count != 8'hFF)
          fault_count <= fault_count + 8'd1;
      end
      if (push && !push_ok)
        overflow <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (mem[rd_ptr]),
    .start (pop),
    .busy  (tx_busy),
    .txd   (txd)
  );
endmodule

// File: doc/pair_fault_logger.md
PAIR_FAULT_LOGGER -- requirements
Module: pair_fault_logger

Interface
REQ-001 The block SHALL have parameter N_PAIR, default 86, giving the number of scanned pin pairs.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the record FIFO depth (power of two).
REQ-003 The block SHALL have parameter BAUD_DIV, default 434, giving clk cycles per UART bit.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 step_valid  in  1  one scan step's compare result is presented this cycle.
REQ-007 step_index  in  7  pair index of that step, 0..N_PAIR-1.
REQ-008 step_fail  in  1  that step's observed vector differed from the driven vector.
REQ-009 txd  out  1  UART 8N1 serial fault log; idle high.
REQ-010 fault_seen  out  1  sticky: at least one fault accepted since reset.
REQ-011 fault_count  out  8  count of distinct failing pairs, saturating at 255.
REQ-012 overflow  out  1  sticky: at least one record dropped on a full FIFO.

Function
REQ-013 The block SHALL ignore any step with step_index >= N_PAIR.
REQ-014 The block SHALL keep an N_PAIR-bit logged map; a failing step whose map bit is already set is not logged again.
REQ-015 A failing step with its map bit clear SHALL set that bit, increment fault_count (saturating), set fault_seen, and push byte {1'b0, step_index}.
REQ-016 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-017 A rejected push SHALL set overflow; the map bit and fault_count SHALL still update.
REQ-018 Registered outputs SHALL reflect a step one cycle after step_valid.
REQ-019 The transmitter FSM SHALL use states IDLE, START, DATA, STOP: IDLE->START when the FIFO is non-empty (pop that cycle); START->DATA, DATA->STOP after the 8th bit, and STOP->IDLE, each after BAUD_DIV cycles.
REQ-020 The frame SHALL be: one start bit low, 8 data bits LSB first, one stop bit high; each bit lasts exactly BAUD_DIV cycles.
REQ-021 For a push at cycle t into an empty FIFO with the FSM in IDLE, txd SHALL go low at cycle t+2.
REQ-022 Frames SHALL be back-to-back with no idle gap while the FIFO is non-empty.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from a count of log2(FIFO_DEPTH)+1 bits.
REQ-024 Simultaneous push and pop on an empty FIFO SHALL not pop; the pushed byte is sent next.

Reset
REQ-025 On rst, txd=1, fault_seen=0, fault_count=0, overflow=0, FIFO empty, logged map cleared, FSM=IDLE, baud counter=0, all effective at the next edge.
REQ-026 rst asserted mid-frame SHALL abort the frame; txd is high the cycle after rst is sampled.

Configuration
REQ-027 With macro PAIR_FAULT_PASS_SUMMARY_EN defined, a step with step_index == N_PAIR-1 ending a round (indices since the previous N_PAIR-1 step) with no step_fail SHALL push byte 0xFF, at most once per reset.
REQ-028 The pass summary push SHALL obey REQ-016/REQ-017 and SHALL not affect fault_count or fault_seen.
REQ-029 Without PAIR_FAULT_PASS_SUMMARY_EN, no summary byte SHALL be emitted and its round-tracking logic SHALL be absent.

Structure
REQ-030 The shared package bga_lab_pkg SHALL hold N_PAIR default, pass-summary code 0xFF, and the TX state enum.
REQ-031 The serial shifter and baud counter SHALL be sub-module uart_tx_8n1 (ports clk, rst, data, start, busy, txd); FIFO, map and counters stay in pair_fault_logger.

Verification
REQ-032 Single fail: step_index=5, step_fail=1 after reset, BAUD_DIV=4 -> txd low at t+2, then 8 bits 1,0,1,0,0,0,0,0, stop high; fault_count=1.
REQ-033 Repeat: index 5 fails in three consecutive rounds -> exactly one 0x05 frame; fault_count=1.
REQ-034 Overflow: 12 distinct failing indices within 12 consecutive cycles, FIFO_DEPTH=8 -> 9 frames sent (one popped early), overflow=1, fault_count=12.
REQ-035 Saturation/ignore: index 90 failing -> no frame, fault_count unchanged; with N_PAIR=127 and 127 unique fails, fault_count reads 127, saturating only past 255 with test override.
REQ-036 Reset mid-frame: rst during DATA bit 3 -> txd=1 next cycle, all outputs zero, FIFO empty.
REQ-037 With PAIR_FAULT_PASS_SUMMARY_EN: two clean rounds of indices 0..85 -> exactly one 0xFF frame; without macro -> txd stays high.
